ssp_host_if: RTL
================

# ssp_host_if

Host-side front end that feeds the SSP block's APB-style register port. Buffers bytes from a host valid/ready stream in a small TX queue and writes them into the SSP TX FIFO, respecting the SSP's TX-full flag. Drains the SSP RX FIFO with a read burst whenever the SSP flags RX-full, returning received bytes to the host as single-cycle pulses. Directly upstream of SSP: drives its PSEL/PWRITE/PWDATA, consumes its PRDATA/SSPTXINTR/SSPRXINTR.

## Interface
- QDEPTH, 4, TX queue depth; power of two, >= 2
- DRAIN_COUNT, 4, reads per RX drain burst; 1..4 (never exceeds SSP RX FIFO depth)

- PCLK  in  1  clock, shared with SSP; all state changes on rising edge
- CLEAR  in  1  asynchronous, active-high reset
- tx_valid  in  1  host byte available
- tx_data  in  8  host byte
- tx_ready  out  1  queue can accept; push on edge with tx_valid & tx_ready
- rx_valid  out  1  one-cycle pulse, rx_data valid
- rx_data  out  8  byte read from SSP
- busy  out  1  FSM not IDLE or TX queue non-empty
- PSEL  out  1  to SSP
- PWRITE  out  1  to SSP; 1 write, 0 read
- PWDATA  out  8  to SSP
- PRDATA  in  8  from SSP, head of SSP RX FIFO
- SSPTXINTR  in  1  SSP TX FIFO full
- SSPRXINTR  in  1  SSP RX FIFO full

## Operation
- SSP contract: write accepted at edge with PSEL=1, PWRITE=1, SSPTXINTR=0; read pops SSP RX FIFO at edge with PSEL=1, PWRITE=0, PRDATA valid in that cycle.
- TX queue: circular FIFO, QDEPTH entries, log2(QDEPTH)+1-bit count; read/write pointers wrap modulo QDEPTH. tx_ready = !full (0 while CLEAR asserted). Full queue rejects push (tx_ready low); pop and push in same cycle both take effect, count unchanged.
- FSM states IDLE, WRITE, DRAIN; PSEL/PWRITE/PWDATA registered, driven per next state.
- IDLE: if SSPRXINTR=1 -> DRAIN, load drain counter with DRAIN_COUNT, PSEL=1, PWRITE=0. Else if queue non-empty and SSPTXINTR=0 -> WRITE, PSEL=1, PWRITE=1, PWDATA=queue head. Else stay, PSEL=0. RX drain has priority over TX when both possible.
- WRITE, each edge: if SSPTXINTR=0, write accepted, pop queue. Then stay in WRITE with PWDATA=next head only if accepted, queue still non-empty after pop, SSPRXINTR=0 and SSPTXINTR=0; otherwise -> IDLE, PSEL=0. A rejected write (SSPTXINTR=1) leaves queue head intact for retry.
- DRAIN, each edge: capture PRDATA into rx_data, pulse rx_valid next cycle, decrement counter; at counter 1 -> IDLE, PSEL=0. Reads are unconditional; host has no backpressure on rx.
- PWDATA holds last value when PSEL=0; PWRITE returns to 0 in IDLE.

## Timing
- Reset values: PSEL=0, PWRITE=0, PWDATA=0, rx_valid=0, rx_data=0, busy=0, tx_ready=0 during CLEAR; queue empty, FSM IDLE.
- CLEAR mid-operation: immediate (asynchronous) return to reset values; queued bytes and in-progress burst discarded.
- TX latency: push at edge E into empty queue -> PSEL/PWRITE=1 with byte after E+1 -> accepted at E+2.
- Back-to-back writes: one byte per cycle while SSPTXINTR stays 0.
- RX: SSPRXINTR sampled 1 at edge E (in IDLE) -> reads at E+1..E+DRAIN_COUNT -> rx_valid pulses after E+2..E+DRAIN_COUNT+1, one per cycle, in SSP FIFO order.
- SSPRXINTR rising during WRITE: current write completes (if accepted), then IDLE for one cycle, then DRAIN.
- SSPTXINTR=1 with non-empty queue: stay IDLE until it falls; busy stays 1.

## Test plan
- Reset: assert CLEAR mid-WRITE burst with 3 bytes queued -> PSEL, PWRITE, rx_valid drop to 0 asynchronously; after release, tx_ready=1, busy=0, no further writes.
- Single write: push 8'h35 at edge E -> PSEL=1, PWRITE=1, PWDATA=8'h35 after E+1, popped at E+2, PSEL=0 after E+2, busy=0.
- Burst and full: push 8'h35,8'hAE,8'h26,8'h39,8'h9D (QDEPTH=4) -> tx_ready low after 4th push; SSP model raises SSPTXINTR after 4 accepts -> 5th byte 8'h9D held, written after SSPTXINTR falls; SSP receives bytes in order exactly once.
- RX drain: SSP model fills RX with 8'h74,8'h8F,8'hB1,8'h55 and raises SSPRXINTR -> 4 reads with PWRITE=0, rx_valid pulses carrying 8'h74,8'h8F,8'hB1,8'h55 on consecutive cycles, then IDLE.
- Priority: TX queue holds 8'h55 and SSPRXINTR=1 in IDLE -> DRAIN first, 8'h55 written only after burst ends.
- Wrap-around: push/pop 10 bytes 8'h00..8'h09 with random tx_valid gaps and SSPTXINTR toggling -> pointers wrap, output order 8'h00..8'h09, no loss or duplication.

Source files
------------

// File: rtl/ssp_host_if.sv
// Host-side front end for the SSP register port: queues host TX bytes into the
// SSP TX FIFO and drains the SSP RX FIFO in fixed-length read bursts.
module ssp_host_if #(
  parameter int QDEPTH      = 4,
  parameter int DRAIN_COUNT = 4
) (
  input  logic       PCLK,
  input  logic       CLEAR,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       PSEL,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       SSPTXINTR,
  input  logic       SSPRXINTR
);

  localparam int AW = $clog2(QDEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [QDEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
  logic [AW:0]   count;
  logic          full, empty, push, pop;
  logic [2:0]    drain_cnt, drain_cnt_nxt;
  logic          psel_nxt, pwrite_nxt;
  logic [7:0]    pwdata_nxt;
  logic [7:0]    rd_hold;
  logic          rd_hold_valid;

  assign full      = (count == (AW+1)'(QDEPTH));
  assign empty     = (count == '0);
  assign tx_ready  = !full && !CLEAR;
  assign push      = tx_valid && tx_ready;
  assign pop       = (state == WRITE) && !SSPTXINTR;
  assign rd_ptr_nx = rd_ptr + 1'b1;
  assign busy      = (state != IDLE) || !empty;

  // NOTE: queue storage has no reset; count and pointers alone define validity.
  always_ff @(posedge PCLK) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge PCLK or posedge CLEAR) begin
    if (CLEAR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr_nx;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    psel_nxt      = 1'b0;
    pwrite_nxt    = 1'b0;
    pwdata_nxt    = PWDATA;
    case (state)
      IDLE: begin
        if (SSPRXINTR) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = 3'(DRAIN_COUNT);
          psel_nxt      = 1'b1;
        end else if (!empty && !SSPTXINTR) begin
          state_nxt  = WRITE;
          psel_nxt   = 1'b1;
          pwrite_nxt = 1'b1;
          pwdata_nxt = mem[rd_ptr];
        end
      end
      WRITE: begin
        // Same-cycle pushes are not forwarded; a lone pushed byte waits for IDLE.
        if (!SSPTXINTR && !SSPRXINTR && count > (AW+1)'(1)) begin
          psel_nxt   = 1'b1;
          pwrite_nxt = 1'b1;
          pwdata_nxt = mem[rd_ptr_nx];
        end else begin
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        drain_cnt_nxt = drain_cnt - 1'b1;
        if (drain_cnt == 3'd1) state_nxt = IDLE;
        else                   psel_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments.
  always_ff @(posedge PCLK or posedge CLEAR) begin
    if (CLEAR) begin
      state         <= IDLE;
      drain_cnt     <= '0;
      PSEL          <= 1'b0;
      PWRITE        <= 1'b0;
      PWDATA        <= '0;
      rd_hold       <= '0;
      rd_hold_valid <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      PSEL      <= psel_nxt;
      PWRITE    <= pwrite_nxt;
      PWDATA    <= pwdata_nxt;
      // Read data is staged once so the host pulse trails the SSP read by a cycle.
      rd_hold_valid <= (state == DRAIN);
      if (state == DRAIN) rd_hold <= PRDATA;
      rx_valid <= rd_hold_valid;
      if (rd_hold_valid) rx_data <= rd_hold;
    end
  end

endmodule
